// File: rtl/memory_stage_if.sv
// -----------------------------------------------------------------------------
// memory_stage_if
// Data-memory bus between the pipeline memory stage and the memory/cache.
//
// Signals (names are seen from the memory stage):
//   mem_req_o    request valid; held until mem_ack_i
//   mem_we_o     request is a write
//   mem_addr_o   word-aligned byte address
//   mem_wdata_o  write data
//   mem_ack_i    one-cycle completion strobe
//   mem_rdata_i  read data, valid in the mem_ack_i cycle
//
// Modports:
//   master  used by memory_stage (drives the request)
//   slave   used by the memory model / cache (drives ack and read data)
// -----------------------------------------------------------------------------
interface memory_stage_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    input  mem_ack_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    output mem_ack_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
// Pipeline MEM stage with the MEM/WB pipeline register.
//
// Non-memory instructions pass straight to MEM/WB with one cycle of latency.
// Aligned loads/stores are latched, issued on the memory bus and held until
// the memory acknowledges; meanwhile mem_stall_o freezes the earlier stages.
// Misaligned accesses are dropped with a one-cycle misalign_o pulse.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   stall_i               downstream hold; freezes MEM/WB
//   flush_i               kill the current instruction (beats stall_i)
//   result_i              ALU result / byte address of an access
//   read_data2_i          store data
//   pc_i                  pc of the instruction (link value is pc_i + 4)
//   wb_sel_i              00 result, 01 load data, 10 pc+4, 11 result
//   reg_write_enable_i    instruction writes a register
//   mem_write_enable_i    access is a store (else a load)
//   mem_cache_valid_i     instruction performs a memory access
//   reg_write_dst_i       destination register
//   mem                   memory bus (memory_stage_if.master)
//   wb_data_o             MEM/WB write-back data (also the forwarding value)
//   reg_write_enable_o    MEM/WB write enable
//   reg_write_dst_o       MEM/WB destination
//   mem_stall_o           hold EX/MEM and earlier stages
//   misalign_o            one-cycle misaligned-access pulse
// -----------------------------------------------------------------------------
module memory_stage (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [31:0]           result_i,
  input  logic [31:0]           read_data2_i,
  input  logic [31:0]           pc_i,
  input  logic [1:0]            wb_sel_i,
  input  logic                  reg_write_enable_i,
  input  logic                  mem_write_enable_i,
  input  logic                  mem_cache_valid_i,
  input  logic [4:0]            reg_write_dst_i,
  memory_stage_if.master        mem,
  output logic [31:0]           wb_data_o,
  output logic                  reg_write_enable_o,
  output logic [4:0]            reg_write_dst_o,
  output logic                  mem_stall_o,
  output logic                  misalign_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state;

  // Instruction latched at request time; the EX/MEM inputs are not trusted
  // while the stage is stalling.
  logic [1:0]  lat_wb_sel;
  logic        lat_reg_write;
  logic [4:0]  lat_dst;
  logic [31:0] lat_result;
  logic [31:0] lat_link;

  // Set by a flush that lands while the bus transaction is in flight; the
  // transaction still completes but its register write is suppressed.
  logic        kill;

  // Read data captured when the ack arrives during a downstream stall.
  logic [31:0] cap_rdata;

  logic [31:0] link_value;
  logic        aligned;
  logic        kill_now;

  // Link value wraps naturally at 2^32.
  assign link_value = pc_i + 32'd4;
  assign aligned    = (result_i[1:0] == 2'b00);
  // A flush in the ack cycle kills the completing instruction too.
  assign kill_now   = kill | flush_i;

  assign mem_stall_o = (state != IDLE);

  function automatic logic [31:0] wb_mux(
    input logic [1:0]  sel,
    input logic [31:0] result,
    input logic [31:0] load_data,
    input logic [31:0] link
  );
    logic [31:0] value;
    unique case (sel)
      2'b01:   value = load_data;
      2'b10:   value = link;
      default: value = result;
    endcase
    return value;
  endfunction

  // NOTE: the reset is in the sensitivity list so the bus request and the
  // stall drop the moment rst_i rises, without waiting for a clock edge.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state              <= IDLE;
      lat_wb_sel         <= 2'b00;
      lat_reg_write      <= 1'b0;
      lat_dst            <= 5'd0;
      lat_result         <= 32'd0;
      lat_link           <= 32'd0;
      kill               <= 1'b0;
      cap_rdata          <= 32'd0;
      wb_data_o          <= 32'd0;
      reg_write_enable_o <= 1'b0;
      reg_write_dst_o    <= 5'd0;
      misalign_o         <= 1'b0;
      mem.mem_req_o      <= 1'b0;
      mem.mem_we_o       <= 1'b0;
      mem.mem_addr_o     <= 32'd0;
      mem.mem_wdata_o    <= 32'd0;
    end else begin
      // Pulse output: only asserted in the cycle after a misaligned accept.
      misalign_o <= 1'b0;

      unique case (state)
        IDLE: begin
          if (flush_i) begin
            // Killed instruction becomes a bubble; nothing is issued.
            reg_write_enable_o <= 1'b0;
          end else if (!stall_i) begin
            if (!mem_cache_valid_i) begin
              // Non-memory instruction: load data selection falls back to
              // the ALU result since there is no load data.
              wb_data_o          <= wb_mux(wb_sel_i, result_i, result_i, link_value);
              reg_write_enable_o <= reg_write_enable_i;
              reg_write_dst_o    <= reg_write_dst_i;
            end else if (aligned) begin
              lat_wb_sel         <= wb_sel_i;
              lat_reg_write      <= reg_write_enable_i;
              lat_dst            <= reg_write_dst_i;
              lat_result         <= result_i;
              lat_link           <= link_value;
              kill               <= 1'b0;
              mem.mem_req_o      <= 1'b1;
              mem.mem_we_o       <= mem_write_enable_i;
              mem.mem_addr_o     <= result_i;
              mem.mem_wdata_o    <= read_data2_i;
              reg_write_enable_o <= 1'b0;
              state              <= BUSY;
            end else begin
              misalign_o         <= 1'b1;
              reg_write_enable_o <= 1'b0;
            end
          end
          // stall_i without flush_i: MEM/WB holds and the input waits.
        end

        BUSY: begin
          if (flush_i) begin
            kill <= 1'b1;
          end
          if (mem.mem_ack_i) begin
            mem.mem_req_o <= 1'b0;
            if (kill_now) begin
              // Flush outranks stall: retire the killed access as a bubble.
              reg_write_enable_o <= 1'b0;
              kill               <= 1'b0;
              state              <= IDLE;
            end else if (stall_i) begin
              cap_rdata <= mem.mem_rdata_i;
              state     <= HOLD;
            end else begin
              wb_data_o          <= wb_mux(lat_wb_sel, lat_result, mem.mem_rdata_i, lat_link);
              reg_write_enable_o <= lat_reg_write;
              reg_write_dst_o    <= lat_dst;
              state              <= IDLE;
            end
          end
        end

        HOLD: begin
          if (flush_i) begin
            reg_write_enable_o <= 1'b0;
            kill               <= 1'b0;
            state              <= IDLE;
          end else if (!stall_i) begin
            wb_data_o          <= wb_mux(lat_wb_sel, lat_result, cap_rdata, lat_link);
            reg_write_enable_o <= lat_reg_write;
            reg_write_dst_o    <= lat_dst;
            kill               <= 1'b0;
            state              <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_stage
// Self-checking bench for memory_stage: directed scenarios followed by a
// randomized instruction stream checked against a transaction-level model
// (expected write-back value per instruction plus a reference word memory).
// -----------------------------------------------------------------------------
module tb_memory_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] result_i;
  logic [31:0] read_data2_i;
  logic [31:0] pc_i;
  logic [1:0]  wb_sel_i;
  logic        reg_write_enable_i;
  logic        mem_write_enable_i;
  logic        mem_cache_valid_i;
  logic [4:0]  reg_write_dst_i;
  logic [31:0] wb_data_o;
  logic        reg_write_enable_o;
  logic [4:0]  reg_write_dst_o;
  logic        mem_stall_o;
  logic        misalign_o;

  memory_stage_if mem_bus ();

  memory_stage dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .stall_i            (stall_i),
    .flush_i            (flush_i),
    .result_i           (result_i),
    .read_data2_i       (read_data2_i),
    .pc_i               (pc_i),
    .wb_sel_i           (wb_sel_i),
    .reg_write_enable_i (reg_write_enable_i),
    .mem_write_enable_i (mem_write_enable_i),
    .mem_cache_valid_i  (mem_cache_valid_i),
    .reg_write_dst_i    (reg_write_dst_i),
    .mem                (mem_bus),
    .wb_data_o          (wb_data_o),
    .reg_write_enable_o (reg_write_enable_o),
    .reg_write_dst_o    (reg_write_dst_o),
    .mem_stall_o        (mem_stall_o),
    .misalign_o         (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // ram is the memory the DUT talks to; ref_mem is what the model believes
  // memory holds, updated from the stimulus rather than from the bus.
  logic [31:0] ram     [64];
  logic [31:0] ref_mem [64];

  function automatic logic [31:0] exp_wb(input logic [1:0] sel, input logic [31:0] res,
                                         input logic [31:0] load, input logic [31:0] pc);
    if (sel == 2'b01) return load;
    if (sel == 2'b10) return pc + 32'd4;
    return res;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_nop();
    flush_i = 1'b0; stall_i = 1'b0; mem_cache_valid_i = 1'b0;
    reg_write_enable_i = 1'b0; mem_write_enable_i = 1'b0; wb_sel_i = 2'b00;
    result_i = 32'd0; read_data2_i = 32'd0; pc_i = 32'd0; reg_write_dst_i = 5'd0;
  endtask

  task automatic drive_op(input logic [31:0] res, input logic [31:0] rd2, input logic [31:0] pc,
                          input logic [1:0] sel, input logic rwe, input logic we,
                          input logic valid, input logic [4:0] dst);
    result_i = res; read_data2_i = rd2; pc_i = pc; wb_sel_i = sel;
    reg_write_enable_i = rwe; mem_write_enable_i = we; mem_cache_valid_i = valid;
    reg_write_dst_i = dst;
  endtask

  // Random EX/MEM contents while the stage should be ignoring them.
  task automatic drive_garbage();
    drive_op($urandom, $urandom, $urandom, 2'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 5'($urandom));
  endtask

  task automatic test_reset();
    drive_nop();
    mem_bus.mem_ack_i = 1'b0; mem_bus.mem_rdata_i = 32'd0;
    rst_i = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    n_checks++; if ({wb_data_o, reg_write_enable_o, reg_write_dst_o, mem_stall_o, misalign_o} !== 40'd0)
      begin n_fail++; $display("FAIL reset_async_outputs: got %h required 0", {wb_data_o, reg_write_enable_o, reg_write_dst_o, mem_stall_o, misalign_o}); end
    n_checks++; if ({mem_bus.mem_req_o, mem_bus.mem_we_o, mem_bus.mem_addr_o, mem_bus.mem_wdata_o} !== 66'd0)
      begin n_fail++; $display("FAIL reset_bus: got %h required 0", {mem_bus.mem_req_o, mem_bus.mem_we_o, mem_bus.mem_addr_o, mem_bus.mem_wdata_o}); end
    step(); step();
    rst_i = 1'b0;
    step();
    n_checks++; if ({wb_data_o, reg_write_enable_o, mem_stall_o, mem_bus.mem_req_o} !== 35'd0)
      begin n_fail++; $display("FAIL reset_release: got %h required 0", {wb_data_o, reg_write_enable_o, mem_stall_o, mem_bus.mem_req_o}); end
  endtask

  task automatic test_alu();
    logic [31:0] exp;
    drive_op(32'h12345678, 32'h0, 32'h1000, 2'b00, 1'b1, 1'b0, 1'b0, 5'd5);
    step();
    n_checks++; if ({wb_data_o, reg_write_enable_o, reg_write_dst_o} !== {32'h12345678, 1'b1, 5'd5})
      begin n_fail++; $display("FAIL alu_basic: got %h %b %0d required 12345678 1 5", wb_data_o, reg_write_enable_o, reg_write_dst_o); end
    n_checks++; if ({mem_stall_o, mem_bus.mem_req_o, misalign_o} !== 3'b000)
      begin n_fail++; $display("FAIL alu_no_stall: got %b required 000", {mem_stall_o, mem_bus.mem_req_o, misalign_o}); end
    // Every wb_sel with a pc that wraps when 4 is added.
    for (int s = 1; s < 4; s++) begin
      drive_op(32'hCAFEF00D, 32'h0, 32'hFFFFFFFC, 2'(s), 1'b1, 1'b0, 1'b0, 5'(s + 10));
      step();
      exp = exp_wb(2'(s), 32'hCAFEF00D, 32'hCAFEF00D, 32'hFFFFFFFC);
      n_checks++; if ({wb_data_o, reg_write_dst_o} !== {exp, 5'(s + 10)})
        begin n_fail++; $display("FAIL alu_wb_sel%0d: got %h/%0d required %h/%0d", s, wb_data_o, reg_write_dst_o, exp, s + 10); end
    end
  endtask

  task automatic test_load();
    int stall_cycles = 0;
    drive_op(32'h100, 32'h0, 32'h2000, 2'b01, 1'b1, 1'b0, 1'b1, 5'd7);
    step();
    n_checks++; if ({mem_bus.mem_req_o, mem_bus.mem_we_o, mem_bus.mem_addr_o, reg_write_enable_o} !== {2'b10, 32'h100, 1'b0})
      begin n_fail++; $display("FAIL load_request: got req %b we %b addr %h rwe %b required 1 0 100 0", mem_bus.mem_req_o, mem_bus.mem_we_o, mem_bus.mem_addr_o, reg_write_enable_o); end
    drive_nop();
    for (int c = 0; c < 4; c++) begin
      if (mem_stall_o === 1'b1) stall_cycles++;
      if (c == 3) begin mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'hDEADBEEF; end
      step();
      mem_bus.mem_ack_i = 1'b0;
    end
    n_checks++; if (stall_cycles != 4 || mem_stall_o !== 1'b0)
      begin n_fail++; $display("FAIL load_stall_cycles: got %0d (after %b) required 4 (after 0)", stall_cycles, mem_stall_o); end
    n_checks++; if ({wb_data_o, reg_write_enable_o, reg_write_dst_o, mem_bus.mem_req_o} !== {32'hDEADBEEF, 1'b1, 5'd7, 1'b0})
      begin n_fail++; $display("FAIL load_writeback: got %h %b %0d req %b required deadbeef 1 7 0", wb_data_o, reg_write_enable_o, reg_write_dst_o, mem_bus.mem_req_o); end
  endtask

  task automatic test_min_latency();
    // Accept, ack in the first request cycle, write-back visible after that edge.
    drive_op(32'h8, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0, 1'b1, 5'd3);
    step();
    drive_nop();
    mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'h0F0F1234;
    step();
    mem_bus.mem_ack_i = 1'b0;
    n_checks++; if ({wb_data_o, reg_write_enable_o, mem_stall_o} !== {32'h0F0F1234, 1'b1, 1'b0})
      begin n_fail++; $display("FAIL min_latency: got %h %b stall %b required 0f0f1234 1 0", wb_data_o, reg_write_enable_o, mem_stall_o); end
  endtask

  task automatic test_store();
    drive_op(32'h40, 32'hA5A5A5A5, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 5'd4);
    step();
    for (int c = 0; c < 3; c++) begin
      n_checks++; if ({mem_bus.mem_req_o, mem_bus.mem_we_o, mem_bus.mem_addr_o, mem_bus.mem_wdata_o, reg_write_enable_o} !== {2'b11, 32'h40, 32'hA5A5A5A5, 1'b0})
        begin n_fail++; $display("FAIL store_stable_c%0d: got %b %b %h %h rwe %b required 1 1 40 a5a5a5a5 0", c, mem_bus.mem_req_o, mem_bus.mem_we_o, mem_bus.mem_addr_o, mem_bus.mem_wdata_o, reg_write_enable_o); end
      drive_garbage();
      if (c == 2) mem_bus.mem_ack_i = 1'b1;
      step();
      mem_bus.mem_ack_i = 1'b0;
    end
    n_checks++; if ({mem_bus.mem_req_o, reg_write_enable_o, mem_stall_o} !== 3'b000)
      begin n_fail++; $display("FAIL store_done: got %b required 000", {mem_bus.mem_req_o, reg_write_enable_o, mem_stall_o}); end
    drive_nop();
    step();
  endtask

  task automatic test_misalign();
    drive_op(32'h102, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0, 1'b1, 5'd9);
    step();
    n_checks++; if ({misalign_o, mem_bus.mem_req_o, reg_write_enable_o, mem_stall_o} !== 4'b1000)
      begin n_fail++; $display("FAIL misalign_pulse: got %b required 1000", {misalign_o, mem_bus.mem_req_o, reg_write_enable_o, mem_stall_o}); end
    drive_nop();
    step();
    n_checks++; if ({misalign_o, mem_bus.mem_req_o, mem_stall_o} !== 3'b000)
      begin n_fail++; $display("FAIL misalign_one_cycle: got %b required 000", {misalign_o, mem_bus.mem_req_o, mem_stall_o}); end
  endtask

  task automatic test_stall_idle();
    drive_op(32'h11111111, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd1);
    step();
    drive_op(32'h22222222, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd2);
    stall_i = 1'b1;
    step(); step();
    n_checks++; if ({wb_data_o, reg_write_dst_o} !== {32'h11111111, 5'd1})
      begin n_fail++; $display("FAIL stall_idle_hold: got %h/%0d required 11111111/1", wb_data_o, reg_write_dst_o); end
    stall_i = 1'b0;
    step();
    n_checks++; if ({wb_data_o, reg_write_dst_o, reg_write_enable_o} !== {32'h22222222, 5'd2, 1'b1})
      begin n_fail++; $display("FAIL stall_idle_release: got %h/%0d/%b required 22222222/2/1", wb_data_o, reg_write_dst_o, reg_write_enable_o); end
  endtask

  task automatic test_flush_idle();
    drive_op(32'h33333333, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd3);
    flush_i = 1'b1; stall_i = 1'b1;
    step();
    n_checks++; if (reg_write_enable_o !== 1'b0)
      begin n_fail++; $display("FAIL flush_over_stall: got rwe %b required 0", reg_write_enable_o); end
    stall_i = 1'b0;
    drive_op(32'h44, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0, 1'b1, 5'd4);
    step();
    n_checks++; if ({mem_bus.mem_req_o, mem_stall_o, reg_write_enable_o} !== 3'b000)
      begin n_fail++; $display("FAIL flush_access: got %b required 000", {mem_bus.mem_req_o, mem_stall_o, reg_write_enable_o}); end
    drive_nop();
  endtask

  task automatic test_hold();
    drive_op(32'h100, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0, 1'b1, 5'd9);
    step();
    drive_nop();
    step();
    mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'h0BADF00D; stall_i = 1'b1;
    step();
    mem_bus.mem_ack_i = 1'b0; mem_bus.mem_rdata_i = 32'h99999999;
    step();
    n_checks++; if ({mem_stall_o, mem_bus.mem_req_o, reg_write_enable_o} !== 3'b100)
      begin n_fail++; $display("FAIL hold_frozen: got %b required 100", {mem_stall_o, mem_bus.mem_req_o, reg_write_enable_o}); end
    stall_i = 1'b0;
    step();
    n_checks++; if ({wb_data_o, reg_write_enable_o, reg_write_dst_o, mem_stall_o} !== {32'h0BADF00D, 1'b1, 5'd9, 1'b0})
      begin n_fail++; $display("FAIL hold_release: got %h %b %0d stall %b required 0badf00d 1 9 0", wb_data_o, reg_write_enable_o, reg_write_dst_o, mem_stall_o); end
    // Flush while in HOLD returns to IDLE with a bubble.
    drive_op(32'h104, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0, 1'b1, 5'd10);
    step();
    drive_nop();
    mem_bus.mem_ack_i = 1'b1; stall_i = 1'b1;
    step();
    mem_bus.mem_ack_i = 1'b0; flush_i = 1'b1;
    step();
    flush_i = 1'b0; stall_i = 1'b0;
    n_checks++; if ({mem_stall_o, reg_write_enable_o} !== 2'b00)
      begin n_fail++; $display("FAIL hold_flush: got %b required 00", {mem_stall_o, reg_write_enable_o}); end
  endtask

  task automatic test_flush_busy();
    drive_op(32'h200, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0, 1'b1, 5'd12);
    step();
    drive_nop();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    n_checks++; if (mem_bus.mem_req_o !== 1'b1)
      begin n_fail++; $display("FAIL flush_busy_req_kept: got %b required 1", mem_bus.mem_req_o); end
    step();
    mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'h77777777;
    step();
    mem_bus.mem_ack_i = 1'b0;
    n_checks++; if ({reg_write_enable_o, mem_bus.mem_req_o, mem_stall_o} !== 3'b000)
      begin n_fail++; $display("FAIL flush_busy_no_write: got %b required 000", {reg_write_enable_o, mem_bus.mem_req_o, mem_stall_o}); end
  endtask

  task automatic test_ack_ignored();
    drive_op(32'h55AA55AA, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 5'd6);
    mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'h12121212;
    step();
    mem_bus.mem_ack_i = 1'b0;
    n_checks++; if ({wb_data_o, mem_stall_o, mem_bus.mem_req_o} !== {32'h55AA55AA, 2'b00})
      begin n_fail++; $display("FAIL ack_idle_ignored: got %h %b %b required 55aa55aa 0 0", wb_data_o, mem_stall_o, mem_bus.mem_req_o); end
  endtask

  task automatic test_reset_mid_busy();
    drive_op(32'h300, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0, 1'b1, 5'd8);
    step();
    drive_nop();
    step();
    #2 rst_i = 1'b1;
    #1;
    n_checks++; if ({mem_bus.mem_req_o, mem_stall_o, reg_write_enable_o, wb_data_o} !== 35'd0)
      begin n_fail++; $display("FAIL reset_mid_busy: got req %b stall %b rwe %b wb %h required all 0", mem_bus.mem_req_o, mem_stall_o, reg_write_enable_o, wb_data_o); end
    step();
    rst_i = 1'b0;
    drive_op(32'h600DCAFE, 32'h0, 32'h0, 2'b11, 1'b1, 1'b0, 1'b0, 5'd21);
    step();
    n_checks++; if ({wb_data_o, reg_write_enable_o, mem_stall_o} !== {32'h600DCAFE, 1'b1, 1'b0})
      begin n_fail++; $display("FAIL after_reset_op: got %h %b %b required 600dcafe 1 0", wb_data_o, reg_write_enable_o, mem_stall_o); end
  endtask

  task automatic test_random();
    logic [31:0] res, rd2, pc, load, exp;
    logic [1:0]  sel;
    logic        rwe, we;
    logic [4:0]  dst;
    int          kind, lat, idx;
    for (int i = 0; i < 64; i++) begin ram[i] = $urandom; ref_mem[i] = ram[i]; end
    drive_nop();
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 3);
      sel = 2'($urandom); rwe = 1'($urandom); dst = 5'($urandom);
      pc = $urandom; rd2 = $urandom; idx = $urandom_range(0, 63);
      if (kind == 0) begin
        res = $urandom;
        drive_op(res, rd2, pc, sel, rwe, 1'($urandom), 1'b0, dst);
        step();
        exp = exp_wb(sel, res, res, pc);
        n_checks++; if ({wb_data_o, reg_write_enable_o, reg_write_dst_o, mem_stall_o} !== {exp, rwe, dst, 1'b0})
          begin n_fail++; $display("FAIL rnd_alu #%0d: got %h %b %0d required %h %b %0d", i, wb_data_o, reg_write_enable_o, reg_write_dst_o, exp, rwe, dst); end
      end else if (kind == 3) begin
        res = $urandom;
        if (res[1:0] == 2'b00) res[0] = 1'b1;
        drive_op(res, rd2, pc, sel, rwe, 1'($urandom), 1'b1, dst);
        step();
        n_checks++; if ({misalign_o, mem_bus.mem_req_o, reg_write_enable_o, mem_stall_o} !== 4'b1000)
          begin n_fail++; $display("FAIL rnd_misalign #%0d: got %b required 1000", i, {misalign_o, mem_bus.mem_req_o, reg_write_enable_o, mem_stall_o}); end
      end else begin
        we  = (kind == 2);
        res = 32'(idx) << 2;
        drive_op(res, rd2, pc, sel, rwe, we, 1'b1, dst);
        step();
        lat = $urandom_range(0, 3);
        for (int w = 0; w <= lat; w++) begin
          n_checks++; if ({mem_bus.mem_req_o, mem_bus.mem_we_o, mem_bus.mem_addr_o, mem_bus.mem_wdata_o, reg_write_enable_o, mem_stall_o} !== {1'b1, we, res, rd2, 1'b0, 1'b1})
            begin n_fail++; $display("FAIL rnd_request #%0d: got %b %b %h %h required 1 %b %h %h", i, mem_bus.mem_req_o, mem_bus.mem_we_o, mem_bus.mem_addr_o, mem_bus.mem_wdata_o, we, res, rd2); end
          drive_garbage();
          if (w == lat) begin
            // Memory responder: serve the address the DUT actually presents.
            mem_bus.mem_ack_i = 1'b1;
            if (mem_bus.mem_we_o === 1'b1) begin
              mem_bus.mem_rdata_i = $urandom;
              ram[mem_bus.mem_addr_o[7:2]] = mem_bus.mem_wdata_o;
            end else begin
              mem_bus.mem_rdata_i = ram[mem_bus.mem_addr_o[7:2]];
            end
          end
          step();
          mem_bus.mem_ack_i = 1'b0;
        end
        if (we) begin load = mem_bus.mem_rdata_i; ref_mem[idx] = rd2; end
        else    load = ref_mem[idx];
        exp = exp_wb(sel, res, load, pc);
        n_checks++; if ({wb_data_o, reg_write_enable_o, reg_write_dst_o, mem_bus.mem_req_o, mem_stall_o} !== {exp, rwe, dst, 2'b00})
          begin n_fail++; $display("FAIL rnd_access #%0d: got %h %b %0d req %b required %h %b %0d 0", i, wb_data_o, reg_write_enable_o, reg_write_dst_o, mem_bus.mem_req_o, exp, rwe, dst); end
      end
    end
    drive_nop();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_min_latency();
    test_store();
    test_misalign();
    test_stall_idle();
    test_flush_idle();
    test_hold();
    test_flush_busy();
    test_ack_ignored();
    test_reset_mid_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
